// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port controller: register map,
// register-select decode and edge-mode encodings.
package gpio_pkg;

    localparam int BUS_W  = 32;
    localparam int ADDR_W = 5;

    // Byte offsets of the register map.
    localparam logic [ADDR_W-1:0] OFF_DOUT   = 5'h00;
    localparam logic [ADDR_W-1:0] OFF_DIN    = 5'h04;
    localparam logic [ADDR_W-1:0] OFF_DIR    = 5'h08;
    localparam logic [ADDR_W-1:0] OFF_IE     = 5'h0C;
    localparam logic [ADDR_W-1:0] OFF_MODE   = 5'h10;
    localparam logic [ADDR_W-1:0] OFF_STATUS = 5'h14;
    localparam logic [ADDR_W-1:0] OFF_TOGGLE = 5'h18;
    localparam logic [ADDR_W-1:0] OFF_RSVD   = 5'h1C;

    // Register index, i.e. addr[4:2].
    typedef enum logic [2:0] {
        REG_DOUT   = 3'd0,
        REG_DIN    = 3'd1,
        REG_DIR    = 3'd2,
        REG_IE     = 3'd3,
        REG_MODE   = 3'd4,
        REG_STATUS = 3'd5,
        REG_TOGGLE = 3'd6,
        REG_RSVD   = 3'd7
    } gpio_reg_e;

    // Per-pin MODE bit encoding.
    localparam logic MODE_RISING  = 1'b0;
    localparam logic MODE_FALLING = 1'b1;

    // Byte address to register index; the two low address bits are ignored.
    function automatic gpio_reg_e reg_sel(input logic [ADDR_W-1:0] a);
        return gpio_reg_e'(a[4:2]);
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage synchronizer bringing asynchronous pin inputs into the clk domain.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];

    // Shift the pin values down the flop chain; stage 0 is the metastable one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: register file, output/direction drive, synchronized
// inputs with per-pin rising/falling edge capture into a W1C status register,
// and a level interrupt.
//
// Bus handshake: we and re are single-cycle strobes with no back-pressure.
// A write commits on the clk edge where we=1. A read samples the register on
// the edge where re=1 and presents it on rdata with rvalid=1 for exactly the
// following cycle; rdata is 0 whenever rvalid is 0. With we and re together
// the read returns the contents from before the write.
module gpio_port_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BUS_W-1:0]  wdata,
    output logic [BUS_W-1:0]  rdata,
    output logic              rvalid,
    input  logic [WIDTH-1:0]  GPIO_Port_In,
    output logic [WIDTH-1:0]  GPIO_Port_Out,
    output logic [WIDTH-1:0]  GPIO_Port_OE,
    output logic              irq
);

    // Architectural registers.
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_ie;
    logic [WIDTH-1:0] r_mode;
    logic [WIDTH-1:0] r_status;

    // Edge detection and read path state.
    logic [WIDTH-1:0] r_edge_dly;
    logic [BUS_W-1:0] r_rdata;
    logic             r_rvalid;

    // Decode and datapath wires.
    gpio_reg_e        w_sel;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_status_next;
    logic [BUS_W-1:0] w_rd_mux;
    logic             w_unused_bits;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (GPIO_Port_In),
        .o_sync  (w_sync)
    );

    assign w_sel   = reg_sel(addr);
    assign w_wdata = wdata[WIDTH-1:0];

    // Upper write-data bits and byte-lane address bits carry no meaning here.
    assign w_unused_bits = ^{wdata, addr[1:0]};

    // Edge detect: synchronized value against one more cycle of delay.
    assign w_rise = w_sync & ~r_edge_dly;
    assign w_fall = ~w_sync & r_edge_dly;

    // Select the edge type per pin from MODE.
    always_comb begin
        w_edge = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_edge[i] = (r_mode[i] == MODE_FALLING) ? w_fall[i] : w_rise[i];
        end
    end

    // W1C clear mask; a detected edge overrides a clear of the same bit.
    assign w_clr         = (we && (w_sel == REG_STATUS)) ? w_wdata : '0;
    assign w_status_next = (r_status & ~w_clr) | w_edge;

    // Read mux over current (pre-write) register contents, zero-extended.
    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            REG_DOUT:   w_rd_mux = BUS_W'(r_dout);
            REG_DIN:    w_rd_mux = BUS_W'(w_sync);
            REG_DIR:    w_rd_mux = BUS_W'(r_dir);
            REG_IE:     w_rd_mux = BUS_W'(r_ie);
            REG_MODE:   w_rd_mux = BUS_W'(r_mode);
            REG_STATUS: w_rd_mux = BUS_W'(r_status);
            default:    w_rd_mux = '0;
        endcase
    end

    // Register writes; DIN, TOGGLE readback and the reserved slot hold no state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout   <= '0;
            r_dir    <= '0;
            r_ie     <= '0;
            r_mode   <= '0;
            r_status <= '0;
        end else begin
            r_status <= w_status_next;
            if (we) begin
                case (w_sel)
                    REG_DOUT:   r_dout <= w_wdata;
                    REG_DIR:    r_dir  <= w_wdata;
                    REG_IE:     r_ie   <= w_wdata;
                    REG_MODE:   r_mode <= w_wdata;
                    REG_TOGGLE: r_dout <= r_dout ^ w_wdata;
                    default:    ;
                endcase
            end
        end
    end

    // Delay flop for edge detection; zero at reset so a pin held high reports a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_dly <= '0;
        end else begin
            r_edge_dly <= w_sync;
        end
    end

    // Registered read response: one-cycle latency, rdata forced to 0 when not valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= re;
            r_rdata  <= re ? w_rd_mux : '0;
        end
    end

    assign rdata         = r_rdata;
    assign rvalid        = r_rvalid;
    assign GPIO_Port_Out = r_dout;
    assign GPIO_Port_OE  = r_dir;
    assign irq           = |(r_status & r_ie);

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Self-checking bench for gpio_port_ctrl: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_gpio_port_ctrl;

    localparam int W = 10;
    localparam int S = 2;

    localparam logic [4:0] A_DOUT   = 5'h00;
    localparam logic [4:0] A_DIN    = 5'h04;
    localparam logic [4:0] A_DIR    = 5'h08;
    localparam logic [4:0] A_IE     = 5'h0C;
    localparam logic [4:0] A_MODE   = 5'h10;
    localparam logic [4:0] A_STATUS = 5'h14;
    localparam logic [4:0] A_TOGGLE = 5'h18;
    localparam logic [4:0] A_RSVD   = 5'h1C;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic          re;
    logic [4:0]    addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          rvalid;
    logic [W-1:0]  pin_in;
    logic [W-1:0]  pout;
    logic [W-1:0]  poe;
    logic          irq;

    int checks = 0;
    int passed = 0;

    // Reference model state.
    logic [W-1:0]  m_dout, m_dir, m_ie, m_mode, m_status;
    logic          m_rvalid;
    logic [W-1:0]  hist[$];      // hist[j] = pin value sampled j+1 edges ago
    logic [31:0]   exp_q[$];     // expected read data, in issue order

    gpio_port_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk           (clk),
        .rst           (rst),
        .we            (we),
        .re            (re),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .GPIO_Port_In  (pin_in),
        .GPIO_Port_Out (pout),
        .GPIO_Port_OE  (poe),
        .irq           (irq)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic model_reset();
        m_dout = '0; m_dir = '0; m_ie = '0; m_mode = '0; m_status = '0;
        m_rvalid = 1'b0;
        hist.delete();
        repeat (S + 1) hist.push_back('0);
        exp_q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return 32'(m_dout);
            3'd1:    return 32'(hist[S-1]);
            3'd2:    return 32'(m_dir);
            3'd3:    return 32'(m_ie);
            3'd4:    return 32'(m_mode);
            3'd5:    return 32'(m_status);
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock: update the model from pre-edge state, then let the
    // DUT take the edge and return 1 time unit later.
    task automatic tick();
        logic [W-1:0] now_v, prev_v, edges, wd, dummy;
        now_v  = hist[S-1];
        prev_v = hist[S];
        edges  = (~m_mode & now_v & ~prev_v) | (m_mode & ~now_v & prev_v);
        if (re) exp_q.push_back(model_read(addr));
        m_rvalid = re;
        wd = wdata[W-1:0];
        if (we && addr[4:2] == 3'd5) m_status = (m_status & ~wd) | edges;
        else                         m_status = m_status | edges;
        if (we) begin
            case (addr[4:2])
                3'd0: m_dout = wd;
                3'd2: m_dir  = wd;
                3'd3: m_ie   = wd;
                3'd4: m_mode = wd;
                3'd6: m_dout = m_dout ^ wd;
                default: ;
            endcase
        end
        hist.push_front(pin_in);
        dummy = hist.pop_back();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0; wdata = '0;
    endtask

    task automatic rd(input logic [4:0] a);
        re = 1'b1; addr = a;
        tick();
        re = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; pin_in = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++; if ({pout, poe} !== '0) $display("FAIL reset_pins out=%h oe=%h exp 0", pout, poe); else passed++;
        checks++; if ({irq, rvalid, rdata} !== '0) $display("FAIL reset_bus irq=%b rvalid=%b rdata=%h exp 0", irq, rvalid, rdata); else passed++;
        rst = 1'b0;
        tick();
        checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) $display("FAIL reset_idle rvalid=%b rdata=%h exp 0/0", rvalid, rdata); else passed++;
    endtask

    task automatic test_dout_dir();
        logic [31:0] e;
        wr(A_DOUT, 32'h2AA);
        checks++; if (pout !== 10'h2AA) $display("FAIL dout_out got=%h exp=2aa", pout); else passed++;
        wr(A_DIR, 32'h3FF);
        checks++; if (poe !== 10'h3FF) $display("FAIL dir_oe got=%h exp=3ff", poe); else passed++;
        rd(A_DOUT);
        e = exp_q.pop_front();
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h0000_02AA) $display("FAIL dout_read rvalid=%b rdata=%h exp 1/000002aa", rvalid, rdata); else passed++;
        checks++; if (rdata !== e) $display("FAIL dout_read_model rdata=%h exp=%h", rdata, e); else passed++;
        tick();
        checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) $display("FAIL rvalid_pulse rvalid=%b rdata=%h exp 0/0", rvalid, rdata); else passed++;
    endtask

    task automatic test_din_status();
        logic [31:0] e;
        pin_in = 10'd2;
        repeat (2) tick();
        rd(A_DIN);
        e = exp_q.pop_front();
        checks++; if (rdata !== 32'h2 || e !== 32'h2) $display("FAIL din_read rdata=%h model=%h exp 2", rdata, e); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL irq_masked got=%b exp 0", irq); else passed++;
        rd(A_STATUS);
        e = exp_q.pop_front();
        checks++; if (rdata !== 32'h2 || e !== 32'h2) $display("FAIL status_rise rdata=%h model=%h exp 2", rdata, e); else passed++;
        wr(A_IE, 32'h2);
        checks++; if (irq !== 1'b1) $display("FAIL irq_enabled got=%b exp 1", irq); else passed++;
    endtask

    task automatic test_falling();
        logic [31:0] e;
        wr(A_STATUS, 32'hFFFF_FFFF);
        wr(A_MODE, 32'h1);
        pin_in = 10'h3;                 // pin0 rises: ignored in falling mode
        repeat (S + 2) tick();
        rd(A_STATUS);
        e = exp_q.pop_front();
        checks++; if (rdata !== 32'h0 || e !== 32'h0) $display("FAIL fall_mode_rise rdata=%h model=%h exp 0", rdata, e); else passed++;
        pin_in = 10'h2;                 // pin0 falls
        repeat (S + 2) tick();
        rd(A_STATUS);
        e = exp_q.pop_front();
        checks++; if (rdata !== 32'h1 || e !== 32'h1) $display("FAIL fall_mode_fall rdata=%h model=%h exp 1", rdata, e); else passed++;
        wr(A_STATUS, 32'h1);
        wr(A_MODE, 32'h0);
    endtask

    task automatic test_w1c_priority();
        logic [31:0] e;
        pin_in = 10'h0;
        repeat (S + 2) tick();
        pin_in = 10'h2;
        repeat (S) tick();
        wr(A_STATUS, 32'h2);            // lands on the edge that sets STATUS[1]
        rd(A_STATUS);
        e = exp_q.pop_front();
        checks++; if (rdata !== 32'h2 || e !== 32'h2) $display("FAIL w1c_set_wins rdata=%h model=%h exp 2", rdata, e); else passed++;
        checks++; if (irq !== 1'b1) $display("FAIL w1c_irq_held got=%b exp 1", irq); else passed++;
        wr(A_STATUS, 32'h2);
        checks++; if (irq !== 1'b0) $display("FAIL w1c_irq_clr got=%b exp 0", irq); else passed++;
        rd(A_STATUS);
        e = exp_q.pop_front();
        checks++; if (rdata !== 32'h0 || e !== 32'h0) $display("FAIL w1c_cleared rdata=%h model=%h exp 0", rdata, e); else passed++;
    endtask

    task automatic test_toggle_unmapped();
        logic [31:0] e;
        wr(A_DOUT, 32'hFFFF_FC0F);      // upper bits dropped
        checks++; if (pout !== 10'h00F) $display("FAIL dout_upper got=%h exp=00f", pout); else passed++;
        wr(A_TOGGLE, 32'h0FF);
        checks++; if (pout !== 10'h0F0) $display("FAIL toggle got=%h exp=0f0", pout); else passed++;
        rd(A_TOGGLE);
        e = exp_q.pop_front();
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h0) $display("FAIL toggle_read rvalid=%b rdata=%h exp 1/0", rvalid, rdata); else passed++;
        wr(A_RSVD, 32'h3FF);
        wr(A_DIN, 32'h3FF);
        checks++; if (pout !== 10'h0F0 || poe !== 10'h3FF) $display("FAIL ignored_wr out=%h oe=%h exp 0f0/3ff", pout, poe); else passed++;
        rd(A_RSVD);
        e = exp_q.pop_front();
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h0 || e !== 32'h0) $display("FAIL rsvd_read rvalid=%b rdata=%h exp 1/0", rvalid, rdata); else passed++;
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] e;
        we = 1'b1; re = 1'b1; addr = A_DOUT; wdata = 32'h155;
        tick();
        we = 1'b0; re = 1'b0;
        e = exp_q.pop_front();
        checks++; if (rdata !== 32'h0F0 || e !== 32'h0F0) $display("FAIL rw_old_data rdata=%h model=%h exp 0f0", rdata, e); else passed++;
        checks++; if (pout !== 10'h155) $display("FAIL rw_new_out got=%h exp=155", pout); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int n = 0; n < 400; n++) begin
            we    = ($urandom_range(0, 3) == 0);
            re    = ($urandom_range(0, 2) == 0);
            addr  = 5'($urandom_range(0, 31));
            wdata = $urandom;
            if ($urandom_range(0, 3) == 0) pin_in = W'($urandom);
            tick();
            checks++; if (pout !== m_dout || poe !== m_dir) $display("FAIL rnd_pins n=%0d out=%h oe=%h exp %h/%h", n, pout, poe, m_dout, m_dir); else passed++;
            checks++; if (irq !== |(m_status & m_ie)) $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, irq, |(m_status & m_ie)); else passed++;
            checks++; if (rvalid !== m_rvalid) $display("FAIL rnd_rvalid n=%0d got=%b exp=%b", n, rvalid, m_rvalid); else passed++;
            e = m_rvalid ? exp_q.pop_front() : 32'h0;
            checks++; if (rdata !== e) $display("FAIL rnd_rdata n=%0d addr=%h got=%h exp=%h", n, addr, rdata, e); else passed++;
        end
        we = 1'b0; re = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        wr(A_DOUT, 32'h3C3);
        wr(A_DIR, 32'h0FF);
        wr(A_IE, 32'h3FF);
        pin_in = 10'h0;
        re = 1'b1; addr = A_DOUT;
        tick();                          // rvalid now high, another read in flight
        void'(exp_q.pop_front());
        #2 rst = 1'b1;
        #1;
        checks++; if ({pout, poe, irq} !== '0) $display("FAIL rst_async_pins out=%h oe=%h irq=%b exp 0", pout, poe, irq); else passed++;
        checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) $display("FAIL rst_async_bus rvalid=%b rdata=%h exp 0/0", rvalid, rdata); else passed++;
        re = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        tick();
        checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) $display("FAIL rst_no_rvalid rvalid=%b rdata=%h exp 0/0", rvalid, rdata); else passed++;
        checks++; if (pout !== 10'h0 || poe !== 10'h0) $display("FAIL rst_release out=%h oe=%h exp 0", pout, poe); else passed++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_dout_dir();
        test_din_status();
        test_falling();
        test_w1c_priority();
        test_toggle_unmapped();
        test_rw_same_cycle();
        test_random();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
